jmp_seq_checker: RTL and testbench
==================================

# jmp_seq_checker

Receive-side monitor for the 4-bit jump-counter sequence. It samples a `count` stream each enabled clock and predicts the next value from the jump rule. It locks after a run of correct transitions, then reports mismatches, producer restarts and completed laps. It sits downstream of the jump counter, either in the design or in a bench, as the consumer/checker of its `count` bus.

## Interface
Parameters:
- `JMP_FROM`, default 5: value after which the sequence jumps. Legal range 0..14.
- `JMP_TO`, default 10: jump target. Must be in 0..15 and must not equal `JMP_FROM+1`.
- `LOCK_LEN`, default 4: consecutive correct transitions required to lock. Legal range 1..15.

Ports:
- `clk`, input, 1: single clock, rising edge.
- `resetN`, input, 1: asynchronous reset, active-low.
- `en`, input, 1: sample enable. When low, all state is held and no pulses are produced.
- `count_in`, input, 4: observed counter value.
- `locked`, output, 1: level. High while the checker is in the LOCK state.
- `err`, output, 1: one-cycle pulse on a mismatch while locked.
- `restart`, output, 1: one-cycle pulse on an unexpected return to 0 while locked.
- `lap`, output, 1: one-cycle pulse on a correct backward step while locked.
- `err_cnt`, output, 8: error count. Saturates at 255.
- `lap_cnt`, output, 8: lap count. Wraps modulo 256.

## Operation
- Next-value rule, `nxt(p)`:
  - If `p == JMP_FROM`, the next value is `JMP_TO`.
  - Otherwise the next value is `(p+1) mod 16`.
- Registered state: FSM state, `prev` (4b), `good` (4b).
- On every enabled edge, `prev` is loaded with `count_in`. This applies in all states.
- A "match" means `count_in == nxt(prev)`.
- FSM behaviour on enabled edges:
  - **IDLE** (reset state): capture `prev`, clear `good`, go to SYNC. No pulses.
  - **SYNC**, match: increment `good`. If the new `good` equals `LOCK_LEN`, go to LOCK.
  - **SYNC**, mismatch: clear `good` and stay in SYNC. No `err` is produced (the checker is not locked).
  - **LOCK**, match: stay in LOCK. If `nxt(prev) < prev` (wrap or backward jump), pulse `lap` and increment `lap_cnt`.
  - **LOCK**, mismatch with `count_in == 0`: pulse `restart`, clear `good`, go to SYNC. `err_cnt` is unchanged.
  - **LOCK**, any other mismatch: pulse `err`, increment `err_cnt` (saturating), clear `good`, go to SYNC.
- Only one pulse can occur per edge: `err`, `restart` and `lap` are mutually exclusive by construction.
- Arithmetic:
  - Predictor wrap is modulo 16.
  - `err_cnt` holds at 255 once reached.
  - `lap_cnt` rolls over from 255 to 0.

## Timing
- All outputs are registered. Each reflects the sample taken on the same rising edge and is visible after that edge (zero-cycle input-to-register, one cycle to observation).
- Pulses are exactly one `clk` wide. With `en` low they deassert and are not extended.
- Reset values:
  - state IDLE, `locked`=0, `err`=0, `restart`=0, `lap`=0, `err_cnt`=0, `lap_cnt`=0, `prev`=0, `good`=0.
- `resetN` low clears everything immediately, with no clock required, including mid-LOCK and mid-pulse. The first enabled edge after release behaves as IDLE.
- Lock latency from reset release on a clean stream with `en`=1: 1 edge in IDLE plus `LOCK_LEN` matching edges. `locked` rises after edge `LOCK_LEN+1`.
- `en` low on a cycle is transparent: the next enabled sample is compared against the last enabled sample.

## Structure
- Package `jmp_pkg` contains:
  - the `CNT_W=4` and `STAT_W=8` constants;
  - the state enum (IDLE, SYNC, LOCK);
  - the function `jmp_next(p, from, to)`, for sharing with the counter RTL and benches.
- No sub-module is needed. The checker is a single module: FSM plus two counters.

## Test plan
Default parameters apply throughout. The clean sequence is 0,1,2,3,4,5,10,11,12,13,14,15,0,… with `en`=1.
- Reset low for 40 ps, release, then drive the clean stream from 0: `locked`=0 through the sample of 3; `locked`=1 after the edge sampling 4; `err_cnt`=0.
- After lock, run one full lap: no pulse on 5→10; `lap` pulses once on 15→0; `lap_cnt`=1; 300 laps give `lap_cnt`=44.
- Locked at 5, drive 6 instead of 10: `err`=1 for one cycle, `err_cnt`=1, `locked`=0; then 7,8,9,10 give `locked`=1 again (6 seeds `prev`).
- Locked at 12, drive 0, then 1,2,3,4: `restart` pulses, `err_cnt` unchanged, `locked` falls and re-asserts after the sample of 4.
- Locked, `en` low for 3 cycles while `count_in` toggles randomly, then the correct next value: no pulses and `locked` stays 1. Pull `resetN` low between edges: all outputs read 0 before the next edge.
- Toggle lock/error 300 times: `err_cnt` stops at 255.

Source files
------------

// File: rtl/jmp_pkg.sv
// Shared definitions for the jump-counter sequence: widths, checker states
// and the next-value rule used by the counter, the checker and benches.
package jmp_pkg;

    localparam int CNT_W  = 4;
    localparam int STAT_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SYNC = 2'd1,
        ST_LOCK = 2'd2
    } jmp_state_e;

    // Successor of p: jump to 'to_v' right after 'from_v', otherwise +1 mod 16
    function automatic logic [CNT_W-1:0] jmp_next(
        input logic [CNT_W-1:0] p,
        input logic [CNT_W-1:0] from_v,
        input logic [CNT_W-1:0] to_v
    );
        if (p == from_v) begin
            return to_v;
        end
        return p + CNT_W'(1);
    endfunction

endpackage

// File: rtl/jmp_seq_checker.sv
// Receive-side checker for the jump-counter sequence. Synchronises to the
// incoming count stream, locks after LOCK_LEN correct transitions, then
// flags mismatches, producer restarts and completed laps.
module jmp_seq_checker
    import jmp_pkg::*;
#(
    parameter int JMP_FROM = 5,
    parameter int JMP_TO   = 10,
    parameter int LOCK_LEN = 4
) (
    input  logic              clk,
    input  logic              resetN,
    input  logic              en,
    input  logic [CNT_W-1:0]  count_in,
    output logic              locked,
    output logic              err,
    output logic              restart,
    output logic              lap,
    output logic [STAT_W-1:0] err_cnt,
    output logic [STAT_W-1:0] lap_cnt
);

    localparam logic [CNT_W-1:0] FROM_V = CNT_W'(JMP_FROM);
    localparam logic [CNT_W-1:0] TO_V   = CNT_W'(JMP_TO);
    localparam logic [CNT_W-1:0] LOCK_V = CNT_W'(LOCK_LEN);

    jmp_state_e        state_q, state_d;
    logic [CNT_W-1:0]  prev_q, prev_d;
    logic [CNT_W-1:0]  good_q, good_d;
    logic [CNT_W-1:0]  good_inc;
    logic [CNT_W-1:0]  pred;
    logic              match;
    logic              locked_q, locked_d;
    logic              err_q, err_d;
    logic              restart_q, restart_d;
    logic              lap_q, lap_d;
    logic [STAT_W-1:0] err_cnt_q, err_cnt_d;
    logic [STAT_W-1:0] lap_cnt_q, lap_cnt_d;

    assign pred     = jmp_next(prev_q, FROM_V, TO_V);
    assign match    = (count_in == pred);
    assign good_inc = good_q + CNT_W'(1);

    // Next-state logic: FSM, predictor history and status counters
    always_comb begin
        state_d   = state_q;
        prev_d    = prev_q;
        good_d    = good_q;
        err_d     = 1'b0;
        restart_d = 1'b0;
        lap_d     = 1'b0;
        err_cnt_d = err_cnt_q;
        lap_cnt_d = lap_cnt_q;
        if (en) begin
            prev_d = count_in;
            unique case (state_q)
                ST_IDLE: begin
                    good_d  = '0;
                    state_d = ST_SYNC;
                end
                ST_SYNC: begin
                    if (match) begin
                        good_d = good_inc;
                        if (good_inc == LOCK_V) begin
                            state_d = ST_LOCK;
                        end
                    end else begin
                        good_d = '0;
                    end
                end
                ST_LOCK: begin
                    if (match) begin
                        if (pred < prev_q) begin
                            lap_d     = 1'b1;
                            lap_cnt_d = lap_cnt_q + STAT_W'(1);
                        end
                    end else begin
                        good_d  = '0;
                        state_d = ST_SYNC;
                        if (count_in == '0) begin
                            restart_d = 1'b1;
                        end else begin
                            err_d = 1'b1;
                            if (err_cnt_q != '1) begin
                                err_cnt_d = err_cnt_q + STAT_W'(1);
                            end
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
        locked_d = (state_d == ST_LOCK);
    end

    // State and output registers, cleared asynchronously by resetN
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q   <= ST_IDLE;
            prev_q    <= '0;
            good_q    <= '0;
            locked_q  <= 1'b0;
            err_q     <= 1'b0;
            restart_q <= 1'b0;
            lap_q     <= 1'b0;
            err_cnt_q <= '0;
            lap_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            prev_q    <= prev_d;
            good_q    <= good_d;
            locked_q  <= locked_d;
            err_q     <= err_d;
            restart_q <= restart_d;
            lap_q     <= lap_d;
            err_cnt_q <= err_cnt_d;
            lap_cnt_q <= lap_cnt_d;
        end
    end

    assign locked  = locked_q;
    assign err     = err_q;
    assign restart = restart_q;
    assign lap     = lap_q;
    assign err_cnt = err_cnt_q;
    assign lap_cnt = lap_cnt_q;

endmodule

// File: tb/tb_jmp_seq_checker.sv
// Scoreboard bench for jmp_seq_checker: a driver applies directed and random
// samples and queues the expected outputs from a sequence-level model; a
// monitor compares every post-edge output set against the queue.
`timescale 1ns/1ps
module tb_jmp_seq_checker;

    localparam int JMP_FROM = 5;
    localparam int JMP_TO   = 10;
    localparam int LOCK_LEN = 4;

    logic       clk = 1'b0;
    logic       resetN = 1'b0;
    logic       en = 1'b0;
    logic [3:0] count_in = '0;
    logic       locked, err, restart, lap;
    logic [7:0] err_cnt, lap_cnt;

    jmp_seq_checker #(
        .JMP_FROM (JMP_FROM),
        .JMP_TO   (JMP_TO),
        .LOCK_LEN (LOCK_LEN)
    ) dut (
        .clk      (clk),
        .resetN   (resetN),
        .en       (en),
        .count_in (count_in),
        .locked   (locked),
        .err      (err),
        .restart  (restart),
        .lap      (lap),
        .err_cnt  (err_cnt),
        .lap_cnt  (lap_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int locked;
        int err;
        int restart;
        int lap;
        int err_cnt;
        int lap_cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    bit   done     = 0;

    // Sequence-level reference model
    int m_prev, m_run, m_locked, m_started, m_err_cnt, m_lap_cnt;
    int m_err, m_restart, m_lap;
    int cur;

    function automatic int ref_next(input int p);
        return (p == JMP_FROM) ? JMP_TO : (p + 1) % 16;
    endfunction

    task automatic check(input string name, input int act, input int want);
        n_checks++;
        if (act == want) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, want, $time);
    endtask

    task automatic model_reset();
        m_prev = 0; m_run = 0; m_locked = 0; m_started = 0;
        m_err_cnt = 0; m_lap_cnt = 0; m_err = 0; m_restart = 0; m_lap = 0;
    endtask

    task automatic model_sample(input int e, input int c);
        int want;
        m_err = 0; m_restart = 0; m_lap = 0;
        if (e == 0) return;
        if (m_started == 0) begin
            m_started = 1;
            m_run = 0;
        end else begin
            want = ref_next(m_prev);
            if (c == want) begin
                if (m_locked != 0) begin
                    if (want < m_prev) begin
                        m_lap = 1;
                        m_lap_cnt = (m_lap_cnt + 1) % 256;
                    end
                end else begin
                    m_run++;
                    if (m_run == LOCK_LEN) m_locked = 1;
                end
            end else begin
                if (m_locked != 0) begin
                    if (c == 0) m_restart = 1;
                    else begin
                        m_err = 1;
                        if (m_err_cnt < 255) m_err_cnt++;
                    end
                end
                m_locked = 0;
                m_run = 0;
            end
        end
        m_prev = c;
    endtask

    task automatic push_exp();
        exp_t x;
        x.locked = m_locked; x.err = m_err; x.restart = m_restart;
        x.lap = m_lap; x.err_cnt = m_err_cnt; x.lap_cnt = m_lap_cnt;
        exp_q.push_back(x);
    endtask

    // Drive one sample between edges and queue what the next edge must show
    task automatic step(input logic e, input logic [3:0] c);
        @(negedge clk);
        en = e;
        count_in = c;
        if (resetN) model_sample(int'(e), int'(c));
        push_exp();
    endtask

    task automatic clean(input int n);
        for (int i = 0; i < n; i++) begin
            cur = ref_next(cur);
            step(1'b1, 4'(cur));
        end
    endtask

    task automatic clean_until(input int v);
        for (int i = 0; i < 32 && cur != v; i++) clean(1);
    endtask

    task automatic after_edge();
        @(posedge clk);
        #2;
    endtask

    // Monitor: compare each post-edge output set against the queue head
    initial begin : monitor
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                check("locked",  int'(locked),  x.locked);
                check("err",     int'(err),     x.err);
                check("restart", int'(restart), x.restart);
                check("lap",     int'(lap),     x.lap);
                check("err_cnt", int'(err_cnt), x.err_cnt);
                check("lap_cnt", int'(lap_cnt), x.lap_cnt);
            end
        end
    end

    initial begin : watchdog
        #2ms;
        $display("FAIL watchdog: got timeout expected completion");
        $display("%0d/%0d checks passed", n_pass, n_checks + 1);
        $fatal(1, "timeout");
    end

    initial begin : driver
        int laps, bad;
        model_reset();
        #0.04;
        check("rst_locked",  int'(locked),  0);
        check("rst_err_cnt", int'(err_cnt), 0);
        check("rst_lap_cnt", int'(lap_cnt), 0);
        step(1'b1, 4'd7);
        step(1'b1, 4'd7);
        @(negedge clk);
        resetN = 1'b1;

        // Clean stream from 0: lock after the sample of 4
        cur = 0;
        step(1'b1, 4'd0);
        clean(3);
        after_edge();
        check("not_locked_at_3", int'(locked), 0);
        clean(1);
        after_edge();
        check("locked_at_4", int'(locked), 1);

        // 300 laps from reset give lap_cnt 44
        laps = 0;
        while (laps < 300) begin
            clean(1);
            if (cur == 0) laps++;
        end
        after_edge();
        check("lap_cnt_300", int'(lap_cnt), 44);

        // Wrong successor after 5
        clean_until(JMP_FROM);
        step(1'b1, 4'd6);
        cur = 6;
        clean(4);
        clean(3);

        // Producer restart at 12
        clean_until(12);
        step(1'b1, 4'd0);
        cur = 0;
        clean(4);
        clean(2);

        // en low is transparent
        for (int i = 0; i < 3; i++) step(1'b0, 4'($urandom_range(0, 15)));
        clean(3);

        // Asynchronous reset between edges
        @(negedge clk);
        #1;
        resetN = 1'b0;
        model_reset();
        #1;
        check("async_locked",  int'(locked),  0);
        check("async_lap_cnt", int'(lap_cnt), 0);
        check("async_err_cnt", int'(err_cnt), 0);
        step(1'b1, 4'd3);
        @(negedge clk);
        resetN = 1'b1;
        cur = 2;
        clean(6);

        // err_cnt saturation
        for (int i = 0; i < 300; i++) begin
            bad = (ref_next(cur) + 1) % 16;
            if (bad == 0) bad = 2;
            step(1'b1, 4'(bad));
            cur = bad;
            clean(LOCK_LEN);
        end
        after_edge();
        check("err_cnt_sat", int'(err_cnt), 255);

        // Random stream: mostly correct with occasional corruption and stalls
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 9) == 0) step(1'b0, 4'($urandom_range(0, 15)));
            else if ($urandom_range(0, 11) == 0) begin
                cur = $urandom_range(0, 15);
                step(1'b1, 4'(cur));
            end else clean(1);
        end

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) after_edge();
        check("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
